max_finder_seq: RTL and testbench

// Streaming maximum finder. It consumes a frame of unsigned values over a
// val/rdy input handshake and performs one strict greater-than compare per

---
 rtl/max_finder_seq.sv | 98 +++++++++
 tb/tb_max_finder_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/max_finder_seq.sv
// Streaming unsigned max finder: one strict compare per accepted element, result per frame.
// Latency: result valid the cycle after the closing element is accepted.
// Backpressure: input stalls (in_rdy=0) while a result waits; result holds until out_rdy.
module max_finder_seq #(
  parameter int p_nbits   = 4,
  parameter int p_max_len = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_val,
  output logic                           in_rdy,
  input  logic [p_nbits-1:0]             in_data,
  input  logic                           in_last,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [p_nbits-1:0]             out_max,
  output logic [$clog2(p_max_len)-1:0]   out_idx,
  output logic [$clog2(p_max_len):0]     out_len,
  output logic                           out_trunc
);

  localparam int IW = $clog2(p_max_len);
  localparam int LW = IW + 1;

  typedef enum logic {ACCUM, DONE} state_t;

  state_t             state_q, state_nxt;
  logic [p_nbits-1:0] max_q;
  logic [IW-1:0]      idx_q;
  logic [LW-1:0]      len_q;
  logic               trunc_q;

  logic               accept;
  logic               drain;
  logic               at_cap;
  logic               close_frame;
  logic               new_max;
  logic [LW-1:0]      len_inc;

  // Handshakes decoded from state directly so in_rdy/out_val stay pure outputs.
  assign accept      = in_val && !reset && (state_q == ACCUM);
  assign drain       = out_rdy && (state_q == DONE);
  assign len_inc     = len_q + LW'(1);
  assign at_cap      = (len_inc == LW'(p_max_len));
  assign close_frame = accept && (in_last || at_cap);
  // Strict compare keeps the earliest index on ties; first element always loads.
  assign new_max     = (len_q == '0) || (in_data > max_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    in_rdy    = 1'b0;
    out_val   = 1'b0;
    case (state_q)
      ACCUM: begin
        in_rdy = !reset;
        if (close_frame) state_nxt = DONE;
      end
      DONE: begin
        out_val = !reset;
        if (out_rdy) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      trunc_q <= 1'b0;
    end else if (accept) begin
      if (new_max) begin
        max_q <= in_data;
        idx_q <= len_q[IW-1:0];
      end
      len_q   <= len_inc;
      trunc_q <= at_cap && !in_last;
    end else if (drain) begin
      len_q   <= '0;
      trunc_q <= 1'b0;
    end
  end

  assign out_max   = max_q;
  assign out_idx   = idx_q;
  assign out_len   = len_q;
  assign out_trunc = trunc_q;

endmodule

// File: tb/tb_max_finder_seq.sv
// Directed and random frames against max_finder_seq with a result scoreboard.
module tb_max_finder_seq;

  typedef struct packed {
    logic [3:0] mx;
    logic [3:0] idx;
    logic [4:0] len;
    logic       trunc;
  } res_t;

  logic       clk;
  logic       reset;
  logic       in_val;
  logic       in_rdy;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_val;
  logic       out_rdy;
  logic [3:0] out_max;
  logic [3:0] out_idx;
  logic [4:0] out_len;
  logic       out_trunc;

  int   checks   = 0;
  int   failures = 0;
  bit   rand_rdy = 0;
  bit   bubbles  = 0;
  res_t exp_q[$];
  res_t held;
  bit   hold_v   = 0;

  max_finder_seq #(.p_nbits(4), .p_max_len(16)) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data), .in_last(in_last),
    .out_val(out_val), .out_rdy(out_rdy), .out_max(out_max), .out_idx(out_idx),
    .out_len(out_len), .out_trunc(out_trunc)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Inputs change only 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_val  = 0;
      in_data = 4'($urandom);
      in_last = 1'($urandom);
      step();
    end
  endtask

  task automatic send(input logic [3:0] d, input logic last);
    int t = 0;
    if (bubbles) idle($urandom_range(0, 2));
    in_val  = 1;
    in_data = d;
    in_last = last;
    while (!in_rdy && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) chk("in_rdy_timeout", 0, 1);
    step();
    in_val = 0;
  endtask

  task automatic do_reset();
    reset  = 1;
    in_val = 0;
    step();
    step();
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_val", out_val, 0);
    reset = 0;
    step();
    chk("post_rst_data", {out_max, out_idx, out_len, out_trunc}, 0);
    chk("post_rst_in_rdy", in_rdy, 1);
    chk("post_rst_out_val", out_val, 0);
  endtask

  // Scoreboard and hold-stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("hold_val", out_val, 1);
        chk("hold_dat", {out_max, out_idx, out_len, out_trunc}, held);
      end
      if (out_val && out_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexp_result", exp_q.size(), 1);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("res_max", out_max, e.mx);
          chk("res_idx", out_idx, e.idx);
          chk("res_len", out_len, e.len);
          chk("res_trunc", out_trunc, e.trunc);
        end
      end
      hold_v = out_val && !out_rdy;
      held   = {out_max, out_idx, out_len, out_trunc};
    end
  end

  initial begin
    reset   = 1;
    in_val  = 0;
    in_data = 0;
    in_last = 0;
    out_rdy = 1;
    do_reset();

    // 1: {3,9,2,9}, tie keeps index 1
    exp_q.push_back('{4'd9, 4'd1, 5'd4, 1'b0});
    send(3, 0); send(9, 0); send(2, 0);
    chk("t1_in_rdy_mid", in_rdy, 1);
    send(9, 1);
    chk("t1_latency", out_val, 1);
    chk("t1_in_rdy_done", in_rdy, 0);
    step();

    // 2: single element, then {15,14}
    exp_q.push_back('{4'd0, 4'd0, 5'd1, 1'b0});
    send(0, 1);
    step();
    exp_q.push_back('{4'd15, 4'd0, 5'd2, 1'b0});
    send(15, 0); send(14, 1);
    chk("t2_out_val", out_val, 1);
    step();
    chk("t2_in_rdy_after_drain", in_rdy, 1);
    chk("t2_out_val_after_drain", out_val, 0);

    // 3: backpressure on {1,5}
    out_rdy = 0;
    exp_q.push_back('{4'd5, 4'd1, 5'd2, 1'b0});
    send(1, 0); send(5, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_bp_out_val", out_val, 1);
      chk("t3_bp_in_rdy", in_rdy, 0);
      chk("t3_bp_max", out_max, 5);
      chk("t3_bp_idx", out_idx, 1);
      step();
    end
    out_rdy = 1;
    step();
    chk("t3_drained", out_val, 0);

    // 4: 0..15 without last, forced close
    exp_q.push_back('{4'd15, 4'd15, 5'd16, 1'b1});
    for (int i = 0; i < 16; i++) send(4'(i), 0);
    chk("t4_out_val", out_val, 1);
    chk("t4_trunc", out_trunc, 1);
    step();

    // 5: reset mid-frame discards {7,8}; bubbles carry garbage
    send(7, 0); send(8, 0);
    do_reset();
    bubbles = 1;
    exp_q.push_back('{4'd2, 4'd0, 5'd1, 1'b0});
    send(2, 1);
    idle(3);
    chk("t5_queue_empty", exp_q.size(), 0);

    // 6: random frames with gaps on both sides
    rand_rdy = 1;
    for (int f = 0; f < 50; f++) begin
      int         len;
      logic       last_on_cap;
      logic [3:0] d;
      res_t       e;
      len = $urandom_range(1, 16);
      last_on_cap = 1'($urandom);
      e = '0;
      for (int i = 0; i < len; i++) begin
        d = 4'($urandom);
        if (i == 0 || d > e.mx) begin
          e.mx  = d;
          e.idx = 4'(i);
        end
      end
      e.len   = 5'(len);
      e.trunc = (len == 16) && !last_on_cap;
      exp_q.push_back(e);
      // Replay the frame in order: regenerate with a second pass stored below.
      exp_q.pop_back();
      begin
        logic [3:0] vals[16];
        e = '0;
        for (int i = 0; i < len; i++) begin
          vals[i] = 4'($urandom);
          if (i == 0 || vals[i] > e.mx) begin
            e.mx  = vals[i];
            e.idx = 4'(i);
          end
        end
        e.len   = 5'(len);
        e.trunc = (len == 16) && !last_on_cap;
        exp_q.push_back(e);
        for (int i = 0; i < len; i++)
          send(vals[i], (i == len - 1) && (len != 16 || last_on_cap));
      end
    end
    rand_rdy = 0;
    out_rdy  = 1;
    begin
      int t = 0;
      while (exp_q.size() != 0 && t < 500) begin
        step();
        t++;
      end
    end
    chk("all_drained", exp_q.size(), 0);
    step();
    chk("final_idle", out_val, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
